wb_regfile: RTL
===============

Name: wb_regfile

Overview:
- Writeback end of the execute-stage interface: consumes the registered `wb_en`/`rd_addr`/`result`/`branch_en` outputs of the execute stage.
- Commits results into the 16x32 general register file and serves the two decode-stage read ports.
- Keeps a per-register busy scoreboard for RAW hazard stalls.
- Runs a branch flush counter that kills wrong-path writebacks and issues after a taken branch.

Parameters:
- NREG, 16, number of general registers
- AW, 4, register address width (log2 NREG)
- DW, 32, register data width
- FLUSH_CYCLES, 2, cycles of writeback/issue suppression after a taken branch (1..7)

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- wb_en_i  input  1  execute stage requests register write
- rd_addr_i  input  AW  destination register of the write
- result_i  input  DW  write data
- branch_en_i  input  1  taken branch reported by the execute stage
- issue_en_i  input  1  decode issues an instruction that writes a register
- issue_rd_i  input  AW  destination of the issued instruction
- rs0_addr_i  input  AW  read port 0 address
- rs1_addr_i  input  AW  read port 1 address
- rs0_value_o  output  DW  read port 0 data
- rs1_value_o  output  DW  read port 1 data
- hazard_o  output  1  a read address is busy; decode must stall
- flush_o  output  1  flush window active
- commit_cnt_o  output  16  count of committed writes

Behaviour:
- Async reset clears:
  - all registers to 0
  - all busy bits to 0
  - the flush counter to 0
  - commit_cnt_o to 0
- Reset outputs: flush_o=0, hazard_o=0, read ports 0.
- Reset asserted mid-flush or mid-write aborts everything; the first edge after release behaves as a fresh start.
- Flush counter fcnt (3 bits); flush_o = (fcnt != 0).
  - fcnt==0 and branch_en_i=1: next edge loads FLUSH_CYCLES.
  - fcnt!=0: decrements by 1 every edge.
  - branch_en_i while fcnt!=0 is wrong-path and ignored; no reload.
- Commit condition: commit = wb_en_i & ~flush_o.
  - The branch instruction's own write (link write, same cycle as branch_en_i with fcnt==0) commits.
  - On commit, regs[rd_addr_i] <= result_i at the edge.
  - Register 0 is ordinary and writable.
- Effective issue: issue_eff = issue_en_i & ~flush_o & ~branch_en_i. Issues in the branch cycle or during the flush window are wrong-path and dropped.
- Scoreboard busy[NREG], priority per edge:
  1. branch_en_i with fcnt==0: all busy bits cleared. The pending commit still writes the register file.
  2. Otherwise: commit clears busy[rd_addr_i]; then issue_eff sets busy[issue_rd_i].
  3. Issue and commit to the same register in the same cycle: set wins (bit stays 1).
- Reads are combinational: rsN_value_o = regs[rsN_addr_i], with same-cycle bypass per the optional feature.
- hazard_o = busy[rs0_addr_i] | busy[rs1_addr_i], combinational. The bypass exception is per the optional feature.
- commit_cnt_o increments by 1 per commit and wraps 0xFFFF -> 0x0000.
- Latency: a write is visible in the array one edge after commit.

Optional Feature:
- Macro: WB_BYPASS_EN
- Defined:
  - When commit is active and rsN_addr_i == rd_addr_i, rsN_value_o = result_i in the same cycle.
  - That port's busy term is masked from hazard_o, unless issue_eff targets the same register that cycle.
- Undefined:
  - Read ports return array contents only.
  - The committing register stays hazardous until the edge after commit.
  - Decode stalls one extra cycle on a back-to-back dependency.

Test Plan:
- Reset then idle: rs0=3, rs1=15 -> values 0, hazard_o=0, flush_o=0, commit_cnt_o=0.
- Issue r5, then next cycle commit r5=0xDEADBEEF; rs0=5 during the commit cycle:
  - WB_BYPASS_EN defined: reads 0xDEADBEEF with hazard_o=0.
  - WB_BYPASS_EN undefined: hazard_o=1 that cycle, 0xDEADBEEF and hazard_o=0 next cycle.
- FLUSH_CYCLES=2: branch_en_i with wb_en_i r14=0x00000040, then writes r1=0x11 and r2=0x22 on the next two cycles:
  - r14=0x40; r1 and r2 unchanged (0).
  - flush_o high exactly 2 cycles.
  - commit_cnt_o=1.
- Issue r7 during the branch cycle and r8 during the flush window -> busy bits stay 0, hazard_o=0 when reading r7/r8.
- Same-cycle issue r4 and commit r4=0x1234 -> r4=0x1234, busy[4]=1, hazard_o=1 when reading r4 next cycle.
- 65537 back-to-back commits -> commit_cnt_o=0x0001. Assert rst mid-flush -> flush_o=0 immediately and all registers read 0.

Source files
------------

// File: rtl/wb_regfile.sv
// Writeback register file: 16x32 registers, RAW busy scoreboard and a post-branch flush window.
// Optional macro WB_BYPASS_EN forwards the committing result to the read ports in the same cycle.
module wb_regfile #(
  parameter int NREG         = 16,
  parameter int AW           = 4,
  parameter int DW           = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wb_en_i,
  input  logic [AW-1:0] rd_addr_i,
  input  logic [DW-1:0] result_i,
  input  logic          branch_en_i,
  input  logic          issue_en_i,
  input  logic [AW-1:0] issue_rd_i,
  input  logic [AW-1:0] rs0_addr_i,
  input  logic [AW-1:0] rs1_addr_i,
  output logic [DW-1:0] rs0_value_o,
  output logic [DW-1:0] rs1_value_o,
  output logic          hazard_o,
  output logic          flush_o,
  output logic [15:0]   commit_cnt_o
);

  logic [DW-1:0]   regs [NREG];
  logic [NREG-1:0] busy;
  logic [2:0]      fcnt;
  logic [15:0]     commit_cnt;
  logic            flush;
  logic            commit;
  logic            issue_eff;
  logic            branch_take;
  logic            haz0;
  logic            haz1;

  assign flush       = (fcnt != 3'd0);
  assign commit      = wb_en_i & ~flush;
  assign issue_eff   = issue_en_i & ~flush & ~branch_en_i;
  // A branch seen inside the flush window is itself wrong-path.
  assign branch_take = branch_en_i & ~flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fcnt <= 3'd0;
    end else if (flush) begin
      fcnt <= fcnt - 3'd1;
    end else if (branch_en_i) begin
      fcnt <= 3'(FLUSH_CYCLES);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      commit_cnt <= 16'd0;
    end else if (commit) begin
      commit_cnt <= commit_cnt + 16'd1;
    end
  end

  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          regs[gi] <= '0;
        end else if (commit && rd_addr_i == AW'(gi)) begin
          regs[gi] <= result_i;
        end
      end

      // Issue set takes priority over commit clear for the same register.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          busy[gi] <= 1'b0;
        end else if (branch_take) begin
          busy[gi] <= 1'b0;
        end else if (issue_eff && issue_rd_i == AW'(gi)) begin
          busy[gi] <= 1'b1;
        end else if (commit && rd_addr_i == AW'(gi)) begin
          busy[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  always_comb begin
    rs0_value_o = regs[rs0_addr_i];
    rs1_value_o = regs[rs1_addr_i];
    haz0        = busy[rs0_addr_i];
    haz1        = busy[rs1_addr_i];
`ifdef WB_BYPASS_EN
    if (commit && rs0_addr_i == rd_addr_i) begin
      rs0_value_o = result_i;
      if (!(issue_eff && issue_rd_i == rs0_addr_i)) haz0 = 1'b0;
    end
    if (commit && rs1_addr_i == rd_addr_i) begin
      rs1_value_o = result_i;
      if (!(issue_eff && issue_rd_i == rs1_addr_i)) haz1 = 1'b0;
    end
`else
    // Without forwarding the committing register stays hazardous until the array holds it.
`endif
  end

  assign hazard_o     = haz0 | haz1;
  assign flush_o      = flush;
  assign commit_cnt_o = commit_cnt;

endmodule
